// File: rtl/acortex_adc_cap.sv
// ---------------------------------------------------------------------------
// acortex_adc_cap
//
// Stereo ADC capture buffer for the audio cortex. A single-cycle start pulse
// from the local-bus decoder records the next 2^P_CAP_DEPTH_W stereo frames
// from the ADC driver into two on-chip RAMs (left and right). Once the capture
// has finished, the host can read both RAMs back at random addresses.
//
// Optional feature (macro ACORTEX_ADC_CAP_TRIG_EN):
//   When defined, a start pulse arms the block instead of starting the
//   capture. The capture begins with the first frame whose left-sample
//   magnitude reaches P_TRIG_THRESH. When undefined, there is no ARM state and
//   no comparator logic.
//
// Ports:
//   clk_ir               system clock
//   rst_il               asynchronous active-low reset
//   adc_lsample_id       left ADC sample (two's complement)
//   adc_rsample_id       right ADC sample (two's complement)
//   adc_sample_valid_ih  one-cycle pulse; both samples are valid
//   start_cap_ih         one-cycle capture start pulse
//   cap_busy_oh          capture armed or in progress (registered)
//   cap_done_oh          one-cycle pulse after the last frame is written
//   lcap_raddr_id        left RAM read address
//   lcap_rdata_od        left RAM read data, 1-clock latency
//   rcap_raddr_id        right RAM read address
//   rcap_rdata_od        right RAM read data, 1-clock latency
// ---------------------------------------------------------------------------
module acortex_adc_cap #(
  parameter int unsigned           P_SAMPLE_W    = 16,
  parameter int unsigned           P_CAP_DEPTH_W = 8,
  parameter logic [P_SAMPLE_W-1:0] P_TRIG_THRESH = 16'd2048
) (
  input  logic                     clk_ir,
  input  logic                     rst_il,
  input  logic [P_SAMPLE_W-1:0]    adc_lsample_id,
  input  logic [P_SAMPLE_W-1:0]    adc_rsample_id,
  input  logic                     adc_sample_valid_ih,
  input  logic                     start_cap_ih,
  output logic                     cap_busy_oh,
  output logic                     cap_done_oh,
  input  logic [P_CAP_DEPTH_W-1:0] lcap_raddr_id,
  output logic [P_SAMPLE_W-1:0]    lcap_rdata_od,
  input  logic [P_CAP_DEPTH_W-1:0] rcap_raddr_id,
  output logic [P_SAMPLE_W-1:0]    rcap_rdata_od
);

  localparam int unsigned DEPTH = 1 << P_CAP_DEPTH_W;
  localparam logic [P_CAP_DEPTH_W-1:0] WPTR_ONE = {{(P_CAP_DEPTH_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef ACORTEX_ADC_CAP_TRIG_EN
    ARM     = 2'd1,
`endif
    CAPTURE = 2'd2
  } state_t;

  state_t                   state_q, state_nxt;
  logic [P_CAP_DEPTH_W-1:0] wptr_q, wptr_nxt;
  logic                     wr_en;
  logic                     done_nxt;

  logic [P_SAMPLE_W-1:0] lram [DEPTH];
  logic [P_SAMPLE_W-1:0] rram [DEPTH];

`ifdef ACORTEX_ADC_CAP_TRIG_EN
  localparam logic [P_SAMPLE_W-1:0] MOST_NEG = {1'b1, {(P_SAMPLE_W-1){1'b0}}};
  localparam logic [P_SAMPLE_W-1:0] MOST_POS = {1'b0, {(P_SAMPLE_W-1){1'b1}}};

  logic [P_SAMPLE_W-1:0] lmag;
  logic                  trig_hit;

  // Left-sample magnitude. Negating the most-negative code would wrap back
  // to itself, so that value is saturated to the largest positive code.
  always_comb begin
    lmag = adc_lsample_id;
    if (adc_lsample_id == MOST_NEG) begin
      lmag = MOST_POS;
    end else if (adc_lsample_id[P_SAMPLE_W-1]) begin
      lmag = -adc_lsample_id;
    end
  end

  assign trig_hit = (lmag >= P_TRIG_THRESH);
`else
  logic unused_thresh;
  assign unused_thresh = ^P_TRIG_THRESH;
`endif

  // Next-state logic. wptr is already 0 when leaving IDLE, so the trigger
  // frame in ARM lands at index 0 and CAPTURE continues from index 1. The
  // final write wraps wptr back to 0 on its own.
  always_comb begin
    state_nxt = state_q;
    wptr_nxt  = wptr_q;
    wr_en     = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        wptr_nxt = '0;
        if (start_cap_ih) begin
`ifdef ACORTEX_ADC_CAP_TRIG_EN
          state_nxt = ARM;
`else
          state_nxt = CAPTURE;
`endif
        end
      end
`ifdef ACORTEX_ADC_CAP_TRIG_EN
      ARM: begin
        if (adc_sample_valid_ih && trig_hit) begin
          wr_en     = 1'b1;
          wptr_nxt  = wptr_q + WPTR_ONE;
          state_nxt = CAPTURE;
        end
      end
`endif
      CAPTURE: begin
        if (adc_sample_valid_ih) begin
          wr_en    = 1'b1;
          wptr_nxt = wptr_q + WPTR_ONE;
          if (wptr_q == '1) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        wptr_nxt  = '0;
      end
    endcase
  end

  // State register and status flags. Busy follows the next state, so it
  // rises on the edge that accepts start and falls with the final write.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      cap_busy_oh <= 1'b0;
      cap_done_oh <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      wptr_q      <= wptr_nxt;
      cap_busy_oh <= (state_nxt != IDLE);
      cap_done_oh <= done_nxt;
    end
  end

  // Capture RAM write port. The contents are deliberately left unreset, so
  // data from an abandoned capture survives a reset.
  always_ff @(posedge clk_ir) begin
    if (wr_en) begin
      lram[wptr_q] <= adc_lsample_id;
      rram[wptr_q] <= adc_rsample_id;
    end
  end

  // Registered read ports. A read and a write to the same address in one
  // cycle return the old entry.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      lcap_rdata_od <= '0;
      rcap_rdata_od <= '0;
    end else begin
      lcap_rdata_od <= lram[lcap_raddr_id];
      rcap_rdata_od <= rram[rcap_raddr_id];
    end
  end

endmodule

// File: doc/acortex_adc_cap.md
# acortex_adc_cap

Stereo ADC capture buffer for the audio cortex. On a single-cycle start pulse from the ACORTEX local-bus decoder, it records the next 2^P_CAP_DEPTH_W stereo frames from the ADC driver into two on-chip RAMs, one for the left channel and one for the right. While capturing it reports a busy flag, then holds the data for random-access readback by the host through the decoder's capture read-address registers. It sits between the ADC driver (upstream) and the local-bus decoder (downstream).

## Interface
Parameters:
- P_SAMPLE_W, 16: sample width, two's complement.
- P_CAP_DEPTH_W, 8: RAM address width; capture length is 2^P_CAP_DEPTH_W frames.
- P_TRIG_THRESH, 16'd2048: magnitude threshold, used only when ACORTEX_ADC_CAP_TRIG_EN is defined.

Ports:
- clk_ir  in  1  Acortex system clock.
- rst_il  in  1  Reset. Asynchronous, active-low.
- adc_lsample_id  in  P_SAMPLE_W  Left ADC sample.
- adc_rsample_id  in  P_SAMPLE_W  Right ADC sample.
- adc_sample_valid_ih  in  1  One-cycle pulse; both samples are valid this cycle.
- start_cap_ih  in  1  One-cycle start pulse from the decoder.
- cap_busy_oh  out  1  1 -> capture armed or in progress.
- cap_done_oh  out  1  One-cycle pulse when the last frame is written.
- lcap_raddr_id  in  P_CAP_DEPTH_W  Left RAM read address.
- lcap_rdata_od  out  P_SAMPLE_W  Left RAM read data, registered.
- rcap_raddr_id  in  P_CAP_DEPTH_W  Right RAM read address.
- rcap_rdata_od  out  P_SAMPLE_W  Right RAM read data, registered.

## Operation
- FSM states: IDLE, ARM (exists only with ACORTEX_ADC_CAP_TRIG_EN), CAPTURE.
- IDLE:
  - start_cap_ih=1 -> CAPTURE, or ARM when the trigger macro is defined.
  - wptr cleared to 0.
- CAPTURE, on each adc_sample_valid_ih:
  - Write L sample to lram[wptr] and R sample to rram[wptr].
  - wptr increments.
  - On the write at wptr = 2^P_CAP_DEPTH_W-1: pulse cap_done_oh, return to IDLE, reset wptr to 0 (wrap).
- cap_busy_oh = (state != IDLE), registered.
- start_cap_ih while busy is ignored. It does not restart and does not extend the capture.
- If start_cap_ih and adc_sample_valid_ih are both high in IDLE, that sample is not captured. Index 0 is the next valid frame, or the trigger frame.
- Readback:
  - lcap_rdata_od <= lram[lcap_raddr_id] every cycle; rcap likewise.
  - Both read ports are independent and are allowed during capture.
  - A same-address read/write returns the old data.
- RAM contents are not reset. Reset affects only the FSM, wptr and output registers.
- Reset mid-capture: return to IDLE immediately and abandon the partial capture. Previously written entries stay in RAM; no cap_done_oh pulse.
- Reset values: cap_busy_oh=0, cap_done_oh=0, lcap_rdata_od=0, rcap_rdata_od=0, state=IDLE, wptr=0.

## Timing
- cap_busy_oh rises on the clock edge after the start_cap_ih cycle.
- A sample is written on the edge ending its valid cycle.
- cap_done_oh is high, and cap_busy_oh falls, in the cycle after the last valid frame.
- Read latency is 1 clock, from raddr change to rdata_od update. The decoder samples at least 2 clocks after setting raddr, so this meets its budget.
- Back-to-back valids on consecutive cycles are supported: one write per cycle, no stall.
- Minimum capture time is 2^P_CAP_DEPTH_W cycles after the trigger. There is no upper bound, since it depends on the ADC rate.

## Configuration
- ACORTEX_ADC_CAP_TRIG_EN defined:
  - Start goes to ARM; cap_busy_oh is 1 while in ARM.
  - In ARM, each valid frame is tested for |adc_lsample_id| >= P_TRIG_THRESH.
  - Magnitude is two's-complement absolute value; the most-negative value saturates to the maximum positive value.
  - The first passing frame is written as index 0 and the FSM enters CAPTURE with wptr=1.
  - Non-passing frames are discarded.
- ACORTEX_ADC_CAP_TRIG_EN undefined: no ARM state and no comparator logic. Capture begins unconditionally with the next valid frame after start. P_TRIG_THRESH is unused.

## Test plan
- Reset, then a start pulse, then 256 valid frames L=n, R=~n at one frame per 4 cycles:
  - cap_busy_oh rises one cycle after start.
  - cap_done_oh pulses once, and busy falls, the cycle after frame 255.
  - Reading addr 0x00/0x7F/0xFF returns L=0/0x7F/0xFF and R=~0/~0x7F/~0xFF.
- Start in the same cycle as a valid frame (L=0xAAAA), then frames from 0x0001 upward: lram[0]=0x0001, and 0xAAAA is absent.
- Second start pulse at frame 100 of a capture, continuous valid every cycle: no restart; done arrives exactly 256 valids after the first start.
- Assert rst_il low at frame 50, then release and start again with frames 0x1000+n:
  - busy clears asynchronously.
  - No done pulse occurs for the aborted capture.
  - The new capture gives lram[0]=0x1000.
- Set lcap_raddr_id=5 and rcap_raddr_id=9 at the same time: each rdata updates 1 clock later with its own entry.
- With ACORTEX_ADC_CAP_TRIG_EN, thresh 2048, left frames 100, -2047, -2048, 5:
  - The FSM stays in ARM through frames 100 and -2047.
  - -2048 (0xF800) triggers and becomes lram[0]; 5 becomes lram[1].
  - A separate case with left frame 0x8000 also triggers.
